// File: rtl/bus_pkg.sv
// Shared types and constants for the bus arbiter slice.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int DEF_MASTER_COUNT = 2;
  localparam int DEF_SLAVE_COUNT  = 3;
  localparam int DEF_TIMEOUT      = 1024;

  // Index width for a field selecting one of n items; never narrower than 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_picker.sv
// Combinational winner search: scans the valid vector starting at 'start'
// and wrapping around, returning the first valid index found.
module arb_picker #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] start,
  output logic [W-1:0] winner,
  output logic         any_valid
);

  int idx;

  // Circular first-valid search from the start index.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(start) + i;
      if (idx >= N) idx = idx - N;
      if (!any_valid && valid[idx]) begin
        any_valid = 1'b1;
        winner    = W'(idx);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Serial bus arbiter: grants one master at a time, routes its tenure to the
// latched target slave, and force-terminates tenures that run TIMEOUT cycles.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise the lowest valid master index always wins.
//
// Handshake: a master holds req (with a stable slave_id) until it is granted and
// ends its tenure with a 1-cycle done pulse or by dropping req. Grant appears one
// cycle after req is sampled in IDLE; every tenure is followed by exactly one
// RELEASE cycle with all outputs low.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter  int MASTER_COUNT = DEF_MASTER_COUNT,
  parameter  int SLAVE_COUNT  = DEF_SLAVE_COUNT,
  parameter  int TIMEOUT      = DEF_TIMEOUT,
  localparam int MID_W        = idx_width(MASTER_COUNT),
  localparam int SID_W        = idx_width(SLAVE_COUNT)
) (
  input  logic                      clk,
  input  logic                      rstN,
  input  logic [MASTER_COUNT-1:0]   req,
  input  logic [MASTER_COUNT*SID_W-1:0] slave_id,
  input  logic [MASTER_COUNT-1:0]   done,
  output logic [MASTER_COUNT-1:0]   grant,
  output logic [MID_W-1:0]          grant_id,
  output logic [SLAVE_COUNT-1:0]    slave_sel,
  output logic                      bus_busy,
  output logic                      timeout_err
);

  localparam int               CNT_W     = idx_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [SID_W:0]   SLAVE_LIM = (SID_W + 1)'(SLAVE_COUNT);

  arb_state_t              state, state_d;
  logic [MASTER_COUNT-1:0] valid, grant_d;
  logic [MID_W-1:0]        start, winner, grant_id_d;
  logic                    any_valid;
  logic [SID_W-1:0]        win_sid;
  logic [SLAVE_COUNT-1:0]  slave_sel_d;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic                    busy_d, terr_d, owner_end;

  // Requests aimed at a nonexistent slave are never eligible.
  always_comb begin
    valid = '0;
    for (int i = 0; i < MASTER_COUNT; i++) begin
      valid[i] = req[i] && ({1'b0, slave_id[i*SID_W +: SID_W]} < SLAVE_LIM);
    end
  end

  arb_picker #(.N(MASTER_COUNT), .W(MID_W)) u_picker (
    .valid     (valid),
    .start     (start),
    .winner    (winner),
    .any_valid (any_valid)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic [MID_W-1:0] rr_ptr;
  assign start = rr_ptr;

  // Search origin moves to the master after the one just granted.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      rr_ptr <= '0;
    end else if (state == IDLE && any_valid) begin
      rr_ptr <= (winner == MID_W'(MASTER_COUNT - 1)) ? '0 : winner + MID_W'(1);
    end
  end
`else
  assign start = '0;
`endif

  assign win_sid   = slave_id[int'(winner)*SID_W +: SID_W];
  // Only the current owner can end its tenure; dropping req counts as done.
  assign owner_end = done[grant_id] | ~req[grant_id];

  // State register.
  always_ff @(posedge clk) begin
    if (!rstN) state <= IDLE;
    else       state <= state_d;
  end

  // Next state and next registered outputs; grant/slave_sel only move on transitions.
  always_comb begin
    state_d     = state;
    grant_d     = grant;
    grant_id_d  = grant_id;
    slave_sel_d = slave_sel;
    cnt_d       = cnt;
    busy_d      = bus_busy;
    terr_d      = 1'b0;
    case (state)
      IDLE: begin
        if (any_valid) begin
          state_d             = BUSY;
          grant_d             = '0;
          grant_d[winner]     = 1'b1;
          grant_id_d          = winner;
          slave_sel_d         = '0;
          slave_sel_d[win_sid] = 1'b1;
          cnt_d               = '0;
          busy_d              = 1'b1;
        end
      end
      BUSY: begin
        if (owner_end || cnt == CNT_LAST) begin
          state_d     = RELEASE;
          grant_d     = '0;
          slave_sel_d = '0;
          busy_d      = 1'b0;
          cnt_d       = '0;
          terr_d      = ~owner_end;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      RELEASE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output and tenure-counter registers.
  always_ff @(posedge clk) begin
    if (!rstN) begin
      grant       <= '0;
      grant_id    <= '0;
      slave_sel   <= '0;
      bus_busy    <= 1'b0;
      timeout_err <= 1'b0;
      cnt         <= '0;
    end else begin
      grant       <= grant_d;
      grant_id    <= grant_id_d;
      slave_sel   <= slave_sel_d;
      bus_busy    <= busy_d;
      timeout_err <= terr_d;
      cnt         <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter (MASTER_COUNT=2, SLAVE_COUNT=3, TIMEOUT=8).
// Expectations follow ARB_ROUND_ROBIN_EN when it is defined for the build.
module tb_bus_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  localparam int MC = 2;
  localparam int SC = 3;
  localparam int TO = 8;

  logic          clk;
  logic          rstN;
  logic [MC-1:0] req;
  logic [3:0]    slave_id;
  logic [MC-1:0] done;
  logic [MC-1:0] grant;
  logic [0:0]    grant_id;
  logic [SC-1:0] slave_sel;
  logic          bus_busy;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;

  // Tenure start: {grant, grant_id, slave_sel}; tenure end: {busy cycles, timeout_err}.
  logic [5:0] exp_q[$];
  logic [8:0] exp_end_q[$];

  bus_arbiter #(.MASTER_COUNT(MC), .SLAVE_COUNT(SC), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rstN        (rstN),
    .req         (req),
    .slave_id    (slave_id),
    .done        (done),
    .grant       (grant),
    .grant_id    (grant_id),
    .slave_sel   (slave_sel),
    .bus_busy    (bus_busy),
    .timeout_err (timeout_err)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops expectations at each tenure start and end.
  logic prev_busy = 1'b0;
  int   len = 0;
  int   gap = 0;
  bit   gap_valid = 1'b0;

  always @(negedge clk) begin
    logic [5:0] e;
    logic [8:0] ee;
    if (bus_busy === 1'b1 && !prev_busy) begin
      if (gap_valid) begin
        checks++;
        if (gap < 2) begin
          errors++;
          $display("FAIL grant_gap: got %0d idle cycles expected >= 2", gap);
        end
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_grant: got grant=%b slave_sel=%b expected none", grant, slave_sel);
      end else begin
        e = exp_q.pop_front();
        if ({grant, grant_id, slave_sel} !== e) begin
          errors++;
          $display("FAIL grant_start: got grant=%b id=%b sel=%b expected grant=%b id=%b sel=%b",
                   grant, grant_id, slave_sel, e[5:4], e[3], e[2:0]);
        end
      end
      len = 1;
    end else if (bus_busy === 1'b1) begin
      len++;
    end else if (prev_busy) begin
      checks++;
      if (exp_end_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_end: got tenure end len=%0d expected none", len);
      end else begin
        ee = exp_end_q.pop_front();
        if ({8'(len), timeout_err} !== ee) begin
          errors++;
          $display("FAIL tenure_end: got len=%0d terr=%b expected len=%0d terr=%b",
                   len, timeout_err, ee[8:1], ee[0]);
        end
      end
      checks++;
      if (grant !== '0 || slave_sel !== '0) begin
        errors++;
        $display("FAIL release_low: got grant=%b sel=%b expected 0 0", grant, slave_sel);
      end
      gap       = 1;
      gap_valid = (rstN === 1'b1);
    end else begin
      gap++;
    end
    prev_busy = (bus_busy === 1'b1);
  end

  // Driver tasks.
  task automatic wait_grant(input int m);
    int n = 0;
    while (grant[m] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (grant[m] !== 1'b1) begin
      errors++;
      $display("FAIL wait_grant%0d: got grant=%b expected bit %0d set", m, grant, m);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus_busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus_busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: got bus_busy=%b expected 0", bus_busy);
    end
  endtask

  // Wait for master m's grant, hold k cycles, pulse done; optionally drop all requests.
  task automatic do_tenure(input int m, input int k, input bit drop);
    wait_grant(m);
    repeat (k) @(negedge clk);
    done[m] = 1'b1;
    @(negedge clk);
    done = '0;
    if (drop) req = '0;
  endtask

  initial begin
    int m;
    rstN     = 1'b0;
    req      = 2'b11;
    slave_id = {2'd1, 2'd0};
    done     = '0;

    // Reset held with requests pending.
    repeat (3) begin
      @(negedge clk);
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_grant_id", 32'(grant_id), 32'h0);
      check("rst_slave_sel", 32'(slave_sel), 32'h0);
      check("rst_bus_busy", 32'(bus_busy), 32'h0);
      check("rst_timeout_err", 32'(timeout_err), 32'h0);
    end
    req  = '0;
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    // Single master 1 to slave 2.
    slave_id = {2'd2, 2'd0};
    exp_q.push_back({2'b10, 1'b1, 3'b100});
    exp_end_q.push_back({8'd3, 1'b0});
    req = 2'b10;
    do_tenure(1, 2, 1'b1);
    repeat (2) @(negedge clk);

    // Contention with both masters requesting.
    slave_id = {2'd1, 2'd0};
    for (int t = 0; t < 3; t++) begin
      if (RR && t == 1) exp_q.push_back({2'b10, 1'b1, 3'b010});
      else              exp_q.push_back({2'b01, 1'b0, 3'b001});
      exp_end_q.push_back({8'd2, 1'b0});
    end
    req = 2'b11;
    for (int t = 0; t < 3; t++) begin
      m = (RR && t == 1) ? 1 : 0;
      do_tenure(m, 1, t == 2);
    end
    repeat (2) @(negedge clk);

    // Timeout, then re-grant of the still-requesting master ended by done on its last cycle.
    slave_id = {2'd1, 2'd1};
    exp_q.push_back({2'b01, 1'b0, 3'b010});
    exp_end_q.push_back({8'd8, 1'b1});
    exp_q.push_back({2'b01, 1'b0, 3'b010});
    exp_end_q.push_back({8'd8, 1'b0});
    req = 2'b01;
    wait_grant(0);
    wait_idle();
    do_tenure(0, 7, 1'b1);
    repeat (2) @(negedge clk);

    // Out-of-range slave id is never granted.
    slave_id = {2'd0, 2'd3};
    req = 2'b01;
    repeat (10) @(negedge clk);
    check("bad_id_busy", 32'(bus_busy), 32'h0);
    check("bad_id_grant", 32'(grant), 32'h0);
    exp_q.push_back({2'b10, 1'b1, 3'b001});
    exp_end_q.push_back({8'd2, 1'b0});
    req = 2'b11;
    do_tenure(1, 1, 1'b1);
    repeat (2) @(negedge clk);

    // Reset in the middle of a tenure.
    slave_id = {2'd1, 2'd0};
    exp_q.push_back({2'b01, 1'b0, 3'b001});
    exp_end_q.push_back({8'd1, 1'b0});
    req = 2'b01;
    do_tenure(0, 0, 1'b1);
    repeat (2) @(negedge clk);
    if (RR) exp_q.push_back({2'b10, 1'b1, 3'b010});
    else    exp_q.push_back({2'b01, 1'b0, 3'b001});
    exp_end_q.push_back({8'd3, 1'b0});
    req = 2'b11;
    wait_grant(RR ? 1 : 0);
    repeat (2) @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    check("midrst_grant", 32'(grant), 32'h0);
    check("midrst_slave_sel", 32'(slave_sel), 32'h0);
    check("midrst_bus_busy", 32'(bus_busy), 32'h0);
    check("midrst_grant_id", 32'(grant_id), 32'h0);
    exp_q.push_back({2'b01, 1'b0, 3'b001});
    exp_end_q.push_back({8'd1, 1'b0});
    #1 rstN = 1'b1;
    do_tenure(0, 0, 1'b1);
    repeat (5) @(negedge clk);

    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    check("exp_end_q_drained", 32'(exp_end_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
